// File: rtl/sad_pkg.sv
// sad_pkg: shared state encoding, lane-candidate layout and SAD all-ones helper
package sad_pkg;
  typedef enum logic [1:0] {IDLE, SEARCH, DRAIN, HOLD} state_t;
  localparam int SAD_W_MAX = 32;
  localparam int MV_W_MAX = 16;
  typedef struct packed {
    logic [SAD_W_MAX-1:0] sad;
    logic [MV_W_MAX-1:0] mv_x;
    logic [MV_W_MAX-1:0] mv_y;
  } lane_cand_t;
  function automatic logic [SAD_W_MAX-1:0] sad_max(input int w);
    return w >= SAD_W_MAX ? '1 : (SAD_W_MAX'(1) << w) - SAD_W_MAX'(1);
  endfunction
endpackage

// File: rtl/sad_lane_reduce.sv
// sad_lane_reduce: combinational min over enabled lanes, lowest lane wins ties
module sad_lane_reduce import sad_pkg::*; #(
  parameter int NUM_CH = 4,
  parameter int SAD_W = 16,
  parameter int MV_W = 6
) (
  input  logic [NUM_CH-1:0]         lane_en,
  input  logic [NUM_CH*SAD_W-1:0]   sad,
  input  logic [NUM_CH*MV_W-1:0]    mv_x,
  input  logic [NUM_CH*MV_W-1:0]    mv_y,
  output logic [SAD_W-1:0]          win_sad,
  output logic [MV_W-1:0]           win_mv_x,
  output logic [MV_W-1:0]           win_mv_y,
  output logic                      any_en,
  output logic [$clog2(NUM_CH+1)-1:0] pop
);
  localparam int PCW = $clog2(NUM_CH + 1);
  logic [SAD_W-1:0] best;
  logic [PCW-1:0] cnt;
  logic any;
  int sel;
  always_comb begin
    best = '1;
    sel = 0;
    any = 1'b0;
    cnt = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (lane_en[i] && (!any || sad[i*SAD_W +: SAD_W] < best)) begin
        best = sad[i*SAD_W +: SAD_W];
        sel = i;
      end
      any = any | lane_en[i];
      cnt = cnt + PCW'(lane_en[i]);
    end
  end
  assign win_sad = best;
  assign win_mv_x = mv_x[sel*MV_W +: MV_W];
  assign win_mv_y = mv_y[sel*MV_W +: MV_W];
  assign any_en = any;
  assign pop = cnt;
endmodule

// File: rtl/sad_min_tracker.sv
// sad_min_tracker: per-beat lane reduce (stage 1) feeding a running minimum (stage 2)
module sad_min_tracker import sad_pkg::*; #(
  parameter int NUM_CH = 4,
  parameter int SAD_W = 16,
  parameter int MV_W = 6,
  parameter int CNT_W = 12
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    cand_valid,
  output logic                    cand_ready,
  input  logic [NUM_CH-1:0]       cand_lane_en,
  input  logic [NUM_CH*SAD_W-1:0] cand_sad,
  input  logic [NUM_CH*MV_W-1:0]  cand_mv_x,
  input  logic [NUM_CH*MV_W-1:0]  cand_mv_y,
  input  logic                    cand_last,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [SAD_W-1:0]        min_sad,
  output logic [MV_W-1:0]         mv_x,
  output logic [MV_W-1:0]         mv_y,
  output logic                    found,
  output logic [CNT_W-1:0]        cand_cnt
);
  localparam int PCW = $clog2(NUM_CH + 1);
  localparam int SW = (CNT_W > PCW ? CNT_W : PCW) + 1;
  localparam logic [SAD_W-1:0] SAD_MAX = SAD_W'(sad_max(SAD_W));
  state_t state, state_nx;
  logic accept, clr, upd;
  logic [SAD_W-1:0] w_sad, s1_sad;
  logic [MV_W-1:0] w_mx, w_my, s1_mx, s1_my;
  logic w_any, s1_valid;
  logic [PCW-1:0] w_pop, s1_pop;
  logic [SW-1:0] sum;
  logic [CNT_W-1:0] cnt_nx;
  sad_lane_reduce #(.NUM_CH(NUM_CH), .SAD_W(SAD_W), .MV_W(MV_W)) u_reduce (
    .lane_en(cand_lane_en), .sad(cand_sad), .mv_x(cand_mv_x), .mv_y(cand_mv_y),
    .win_sad(w_sad), .win_mv_x(w_mx), .win_mv_y(w_my), .any_en(w_any), .pop(w_pop)
  );
  assign cand_ready = state == SEARCH;
  assign res_valid = state == HOLD;
  // start beats a same-cycle beat; in HOLD it is ignored entirely
  assign accept = cand_valid & cand_ready & ~start;
  assign clr = start & (state != HOLD);
  assign upd = s1_valid & (~found | (s1_sad < min_sad));
  assign sum = SW'(cand_cnt) + SW'(s1_pop);
  assign cnt_nx = sum > SW'({CNT_W{1'b1}}) ? '1 : sum[CNT_W-1:0];
  always_ff @(posedge clk)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = start ? SEARCH : IDLE;
      SEARCH:  state_nx = start ? SEARCH : (accept && cand_last) ? DRAIN : SEARCH;
      DRAIN:   state_nx = start ? SEARCH : HOLD;
      HOLD:    state_nx = res_ready ? IDLE : HOLD;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    s1_sad <= w_sad;
    s1_mx <= w_mx;
    s1_my <= w_my;
    s1_pop <= w_pop;
    if (!rst_n || clr) begin
      s1_valid <= 1'b0;
      min_sad <= SAD_MAX;
      mv_x <= '0;
      mv_y <= '0;
      found <= 1'b0;
      cand_cnt <= '0;
    end else begin
      s1_valid <= accept & w_any;
      if (upd) begin
        min_sad <= s1_sad;
        mv_x <= s1_mx;
        mv_y <= s1_my;
        found <= 1'b1;
      end
      if (s1_valid) cand_cnt <= cnt_nx;
    end
  end
endmodule

// File: tb/tb_sad_min_tracker.sv
// tb_sad_min_tracker: directed and random windows against a flat-scan best-candidate model
module tb_sad_min_tracker;
  import sad_pkg::*;
  localparam int N = 4;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, cand_valid = 1'b0, cand_last = 1'b0, res_ready = 1'b0;
  logic [N-1:0] cand_lane_en = '0;
  logic [N*16-1:0] cand_sad = '0;
  logic [N*6-1:0] cand_mv_x = '0, cand_mv_y = '0;
  logic cand_ready, res_valid, found, cand_ready3, res_valid3, found3;
  logic [15:0] min_sad, min_sad3;
  logic [5:0] mv_x, mv_y, mv_x3, mv_y3;
  logic [11:0] cand_cnt;
  logic [2:0] cand_cnt3;
  int total = 0, bad = 0;
  lane_cand_t best;
  logic m_found;
  int m_cnt;
  logic [N*16-1:0] rs;
  logic [N*6-1:0] rx, ry;
  sad_min_tracker #(.NUM_CH(N), .SAD_W(16), .MV_W(6), .CNT_W(12)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cand_valid(cand_valid), .cand_ready(cand_ready),
    .cand_lane_en(cand_lane_en), .cand_sad(cand_sad), .cand_mv_x(cand_mv_x), .cand_mv_y(cand_mv_y),
    .cand_last(cand_last), .res_valid(res_valid), .res_ready(res_ready), .min_sad(min_sad),
    .mv_x(mv_x), .mv_y(mv_y), .found(found), .cand_cnt(cand_cnt)
  );
  sad_min_tracker #(.NUM_CH(N), .SAD_W(16), .MV_W(6), .CNT_W(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start), .cand_valid(cand_valid), .cand_ready(cand_ready3),
    .cand_lane_en(cand_lane_en), .cand_sad(cand_sad), .cand_mv_x(cand_mv_x), .cand_mv_y(cand_mv_y),
    .cand_last(cand_last), .res_valid(res_valid3), .res_ready(res_ready), .min_sad(min_sad3),
    .mv_x(mv_x3), .mv_y(mv_y3), .found(found3), .cand_cnt(cand_cnt3)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic model_clear();
    m_found = 1'b0;
    best = '0;
    best.sad = 32'hFFFF;
    m_cnt = 0;
  endtask
  task automatic beat(input logic [N-1:0] en, input logic [N*16-1:0] s, input logic [N*6-1:0] mx,
                      input logic [N*6-1:0] my, input logic last);
    lane_cand_t c;
    cand_lane_en = en;
    cand_sad = s;
    cand_mv_x = mx;
    cand_mv_y = my;
    cand_valid = 1'b1;
    cand_last = last;
    @(posedge clk); #1;
    cand_valid = 1'b0;
    cand_last = 1'b0;
    for (int i = 0; i < N; i++)
      if (en[i]) begin
        c = '0;
        c.sad = 32'(s[i*16 +: 16]);
        c.mv_x = 16'(mx[i*6 +: 6]);
        c.mv_y = 16'(my[i*6 +: 6]);
        m_cnt++;
        if (!m_found || c.sad < best.sad) begin
          best = c;
          m_found = 1'b1;
        end
      end
  endtask
  task automatic open_window();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    model_clear();
    chk("open_ready", 32'(cand_ready), 1);
  endtask
  task automatic check_res(input string tag);
    chk({tag, "_sad"}, 32'(min_sad), best.sad);
    chk({tag, "_mvx"}, 32'(mv_x), 32'(best.mv_x));
    chk({tag, "_mvy"}, 32'(mv_y), 32'(best.mv_y));
    chk({tag, "_found"}, 32'(found), 32'(m_found));
    chk({tag, "_cnt"}, 32'(cand_cnt), m_cnt > 4095 ? 4095 : m_cnt);
    chk({tag, "_cnt3"}, 32'(cand_cnt3), m_cnt > 7 ? 7 : m_cnt);
    chk({tag, "_sad3"}, 32'(min_sad3), best.sad);
  endtask
  task automatic finish_window(input int hold);
    chk("drain_ready", 32'(cand_ready), 0);
    chk("drain_valid", 32'(res_valid), 0);
    @(posedge clk); #1;
    chk("res_valid", 32'(res_valid), 1);
    check_res("res");
    for (int k = 0; k < hold; k++) begin
      start = k == 3;
      @(posedge clk); #1;
      chk("hold_valid", 32'(res_valid), 1);
      check_res("hold");
    end
    start = 1'b0;
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    chk("idle_valid", 32'(res_valid), 0);
    chk("idle_ready", 32'(cand_ready), 0);
    check_res("idle");
  endtask
  initial begin
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 32'(cand_ready), 0);
    chk("rst_valid", 32'(res_valid), 0);
    chk("rst_sad", 32'(min_sad), 32'hFFFF);
    chk("rst_mv", {mv_x, mv_y}, 0);
    chk("rst_found", 32'(found), 0);
    chk("rst_cnt", 32'(cand_cnt), 0);
    rst_n = 1'b1;
    open_window();
    beat(4'b1111, {16'd90, 16'd12, 16'd12, 16'd40}, {6'd4, 6'd3, 6'd2, 6'd1}, {6'd14, 6'd13, 6'd12, 6'd11}, 1'b1);
    finish_window(0);
    chk("t1_sad", 32'(min_sad), 12);
    chk("t1_mv", {mv_x, mv_y}, {6'd2, 6'd12});
    chk("t1_cnt", 32'(cand_cnt), 4);
    open_window();
    beat(4'b0001, {48'd0, 16'd30}, 24'd1, 24'd1, 1'b0);
    chk("lat_t1", 32'(min_sad), 32'hFFFF);
    beat(4'b0010, {32'd0, 16'd30, 16'd0}, 24'd2 << 6, 24'd2 << 6, 1'b0);
    chk("lat_t2", 32'(min_sad), 30);
    beat(4'b0100, {16'd0, 16'd29, 32'd0}, 24'd3 << 12, 24'd3 << 12, 1'b1);
    chk("tie_keep", 32'(mv_x), 1);
    finish_window(0);
    chk("t2_sad", 32'(min_sad), 29);
    chk("t2_mvx", 32'(mv_x), 3);
    open_window();
    beat(4'b1011, {16'd50, 16'd0, 16'd50, 16'd50}, {6'd7, 6'd9, 6'd6, 6'd5}, 24'd0, 1'b1);
    finish_window(0);
    chk("dis_sad", 32'(min_sad), 50);
    chk("dis_cnt", 32'(cand_cnt), 3);
    open_window();
    beat(4'b0000, {N{16'd1}}, {N{6'd9}}, {N{6'd9}}, 1'b0);
    beat(4'b0000, {N{16'd2}}, {N{6'd9}}, {N{6'd9}}, 1'b1);
    finish_window(0);
    chk("none_found", 32'(found), 0);
    chk("none_sad", 32'(min_sad), 32'hFFFF);
    open_window();
    beat(4'b0001, {48'd0, 16'd5}, 24'd8, 24'd8, 1'b0);
    start = 1'b1;
    cand_valid = 1'b1;
    cand_lane_en = 4'b1111;
    cand_sad = {N{16'd1}};
    @(posedge clk); #1;
    start = 1'b0;
    cand_valid = 1'b0;
    model_clear();
    beat(4'b0001, {48'd0, 16'd20}, 24'd4, 24'd4, 1'b1);
    finish_window(10);
    chk("abort_sad", 32'(min_sad), 20);
    chk("abort_cnt", 32'(cand_cnt), 1);
    open_window();
    beat(4'b0001, {48'd0, 16'd7}, 24'd1, 24'd1, 1'b1);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    model_clear();
    chk("drain_restart", 32'(cand_ready), 1);
    beat(4'b0010, {32'd0, 16'd9, 16'd0}, 24'd5 << 6, 24'd6 << 6, 1'b1);
    finish_window(0);
    chk("restart_sad", 32'(min_sad), 9);
    open_window();
    for (int b = 0; b < 3; b++) beat(4'b1111, {16'd4, 16'd3, 16'd2, 16'd1}, 24'd0, 24'd0, b == 2);
    finish_window(0);
    chk("sat_cnt3", 32'(cand_cnt3), 7);
    chk("sat_cnt", 32'(cand_cnt), 12);
    open_window();
    beat(4'b0001, {48'd0, 16'd3}, 24'd1, 24'd1, 1'b0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_clear();
    chk("mid_rst_ready", 32'(cand_ready), 0);
    check_res("mid_rst");
    for (int w = 0; w < 40; w++) begin
      int nb;
      open_window();
      nb = $urandom_range(1, 5);
      for (int b = 0; b < nb; b++) begin
        for (int i = 0; i < N; i++) begin
          rs[i*16 +: 16] = $urandom_range(0, 7) == 0 ? 16'hFFFF : 16'($urandom_range(0, 40));
          rx[i*6 +: 6] = 6'($urandom);
          ry[i*6 +: 6] = 6'($urandom);
        end
        beat(4'($urandom), rs, rx, ry, b == nb - 1);
      end
      finish_window(w % 7 == 0 ? 2 : 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
